// File: rtl/mcu_bus_arbiter.sv
// Two-master round-robin arbiter for the MCU data bus.
// Responses are routed in order through a small master-ID FIFO.
module mcu_bus_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BW = DATA_WIDTH / 8,
    localparam int PW = $clog2(MAX_OUTSTANDING),
    localparam int CW = PW + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_we,
    input  logic [BW-1:0]         m0_be,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_we,
    input  logic [BW-1:0]         m1_be,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  s_req,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic                  s_we,
    output logic [BW-1:0]         s_be,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_gnt,
    input  logic                  s_rvalid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    output logic [CW-1:0]         outstanding_cnt,
    output logic                  protocol_error
);

    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    logic                       prio_q, prio_d;
    logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
    logic [PW-1:0]              wr_q, wr_d;
    logic [PW-1:0]              rd_q, rd_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       err_q, err_d;

    logic both, sel, full, empty, push, pop, head;

    assign both  = m0_req & m1_req;
    assign sel   = both ? prio_q : m1_req;
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign head  = ids_q[rd_q];

    // Handshake outputs are gated so nothing leaks out while in reset.
    assign s_req = reset_n & (m0_req | m1_req) & ~full;
    assign push  = s_req & s_gnt;
    assign pop   = reset_n & s_rvalid & ~empty;

    assign m0_gnt    = push & ~sel;
    assign m1_gnt    = push & sel;
    assign m0_rvalid = pop & ~head;
    assign m1_rvalid = pop & head;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

    assign s_addr  = sel ? m1_addr  : m0_addr;
    assign s_we    = sel ? m1_we    : m0_we;
    assign s_be    = sel ? m1_be    : m0_be;
    assign s_wdata = sel ? m1_wdata : m0_wdata;

    assign outstanding_cnt = cnt_q;
    assign protocol_error  = err_q;

    always_comb begin
        prio_d = prio_q;
        ids_d  = ids_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        err_d  = err_q | (s_rvalid & empty);
        if (push) begin
            ids_d[wr_q] = sel;
            wr_d        = wr_q + 1'b1;
            if (both) prio_d = ~sel;
        end
        if (pop) rd_d = rd_q + 1'b1;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
            ids_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            ids_q  <= ids_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// Bench for mcu_bus_arbiter: vector table plus an ID scoreboard
// that predicts which master each slave response belongs to.
module tb_mcu_bus_arbiter;

    localparam logic [31:0] A0 = 32'h1A10_0000;
    localparam logic [31:0] A1 = 32'h2000_0040;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 0, m1_req = 0;
    logic [31:0] m0_addr = A0, m1_addr = A1;
    logic        m0_we = 1'b0, m1_we = 1'b1;
    logic [3:0]  m0_be = 4'hF, m1_be = 4'h3;
    logic [31:0] m0_wdata = 32'h1111_1111, m1_wdata = 32'h2222_2222;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_gnt = 0, s_rvalid = 0;
    logic [31:0] s_rdata = '0;
    logic [2:0]  outstanding_cnt;
    logic        protocol_error;

    mcu_bus_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we),
        .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we),
        .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_we(s_we),
        .s_be(s_be), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .outstanding_cnt(outstanding_cnt),
        .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          r0, r1, sg, sv;
        logic [31:0] rd;
        bit          g0, g1, sreq;
        int          cnt;
    } vec_t;

    vec_t tbl[$];
    bit   sb[$];
    bit   err_m;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(bit r0, bit r1, bit sg, bit sv,
                                logic [31:0] rd, bit g0, bit g1,
                                bit sreq, int cnt);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.sg = sg; v.sv = sv; v.rd = rd;
        v.g0 = g0; v.g1 = g1; v.sreq = sreq; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, compare at negedge, advance past posedge.
    task automatic step(input vec_t v, input string tag);
        bit rv0, rv1, id, spur;
        rv0 = 0; rv1 = 0; spur = 0;
        if (v.sv) begin
            if (sb.size() > 0) begin
                id = sb.pop_front();
                rv0 = ~id;
                rv1 = id;
            end else begin
                spur = 1;
            end
        end
        if (v.g0) sb.push_back(1'b0);
        if (v.g1) sb.push_back(1'b1);
        m0_req = v.r0; m1_req = v.r1;
        s_gnt = v.sg; s_rvalid = v.sv; s_rdata = v.rd;
        @(negedge clock);
        chk({tag, " m0_gnt"}, 32'(m0_gnt), 32'(v.g0));
        chk({tag, " m1_gnt"}, 32'(m1_gnt), 32'(v.g1));
        chk({tag, " s_req"}, 32'(s_req), 32'(v.sreq));
        chk({tag, " cnt"}, 32'(outstanding_cnt), 32'(v.cnt));
        chk({tag, " m0_rvalid"}, 32'(m0_rvalid), 32'(rv0));
        chk({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'(rv1));
        chk({tag, " perr"}, 32'(protocol_error), 32'(err_m));
        if (rv0) chk({tag, " m0_rdata"}, m0_rdata, v.rd);
        if (rv1) chk({tag, " m1_rdata"}, m1_rdata, v.rd);
        if (v.g1) begin
            chk({tag, " s_addr"}, s_addr, A1);
            chk({tag, " s_we"}, 32'(s_we), 32'(1'b1));
        end else if (v.g0 || !(v.r0 || v.r1)) begin
            chk({tag, " s_addr"}, s_addr, A0);
        end
        @(posedge clock);
        #1;
        if (spur) err_m = 1'b1;
    endtask

    task automatic hold_reset(int n);
        reset_n = 1'b0;
        sb.delete();
        err_m = 1'b0;
        m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("rst gnt", {m0_gnt, m1_gnt, s_req}, 32'd0);
            chk("rst rvalid", {m0_rvalid, m1_rvalid}, 32'd0);
            chk("rst cnt", 32'(outstanding_cnt), 32'd0);
            chk("rst perr", 32'(protocol_error), 32'd0);
        end
        @(posedge clock);
        #1;
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        err_m = 1'b0;
        // single master read
        tbl.push_back(mk(1,0,1,0,0,            1,0,1,0));
        tbl.push_back(mk(0,0,0,1,32'h1,        0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,            0,0,0,0));
        // contention, alternating grants
        tbl.push_back(mk(1,1,1,0,0,            1,0,1,0));
        tbl.push_back(mk(1,1,1,1,32'hA0A0_0001,0,1,1,1));
        tbl.push_back(mk(1,1,1,1,32'hA0A0_0002,1,0,1,1));
        tbl.push_back(mk(1,1,1,1,32'hA0A0_0003,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,32'hA0A0_0004,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,            0,0,0,0));
        // fill to MAX_OUTSTANDING with m1, then one pop
        tbl.push_back(mk(0,1,1,0,0,            0,1,1,0));
        tbl.push_back(mk(0,1,1,0,0,            0,1,1,1));
        tbl.push_back(mk(0,1,1,0,0,            0,1,1,2));
        tbl.push_back(mk(0,1,1,0,0,            0,1,1,3));
        tbl.push_back(mk(0,1,1,0,0,            0,0,0,4));
        tbl.push_back(mk(0,1,1,1,32'hC0DE_0001,0,0,0,4));
        tbl.push_back(mk(0,1,1,0,0,            0,1,1,3));
        tbl.push_back(mk(0,0,0,1,32'hC0DE_0002,0,0,0,4));
        tbl.push_back(mk(0,0,0,1,32'hC0DE_0003,0,0,0,3));
        tbl.push_back(mk(0,0,0,1,32'hC0DE_0004,0,0,0,2));
        tbl.push_back(mk(0,0,0,1,32'hC0DE_0005,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,            0,0,0,0));
        // push and pop together at count 2
        tbl.push_back(mk(1,0,1,0,0,            1,0,1,0));
        tbl.push_back(mk(0,1,1,0,0,            0,1,1,1));
        tbl.push_back(mk(1,0,1,1,32'hD000_0001,1,0,1,2));
        tbl.push_back(mk(0,0,0,1,32'hD000_0002,0,0,0,2));
        tbl.push_back(mk(0,0,0,1,32'hD000_0003,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,            0,0,0,0));
        // spurious response, error must stick
        tbl.push_back(mk(0,0,0,1,32'hBAD0_0001,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,            0,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,            1,0,1,0));
        tbl.push_back(mk(0,0,0,1,32'h5,        0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,            0,0,0,0));

        hold_reset(10);
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("v%0d", i));
        chk("perr sticky", 32'(protocol_error), 32'd1);

        hold_reset(2);
        chk("perr cleared", 32'(protocol_error), 32'd0);

        // reset while a read is outstanding: late response is spurious
        step(mk(1,0,1,0,0,0+1,0,1,0), "mid0");
        hold_reset(1);
        step(mk(0,0,0,1,32'h7,0,0,0,0), "mid1");
        step(mk(0,0,0,0,0,0,0,0,0), "mid2");
        chk("mid perr", 32'(protocol_error), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu_bus_arbiter.md
Name: mcu_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the MCU data bus (req/gnt/rvalid protocol).
- Shares the peripheral/memory slave port (GPIO, UART, data RAM) between:
  - master 0: the RISC-V core LSU;
  - master 1: the debug/boot loader (UART-driven).
- Round-robin grant, in-order response routing via an ID FIFO, bounded outstanding transactions.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, ID FIFO depth (power of two, >=2); maximum accepted-but-unanswered transactions.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req / m1_req  in  1  master request; held with payload until gnt.
- m0_addr / m1_addr  in  ADDR_WIDTH  address.
- m0_we / m1_we  in  1  1 = write.
- m0_be / m1_be  in  DATA_WIDTH/8  byte enables.
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data.
- m0_gnt / m1_gnt  out  1  request accepted this cycle.
- m0_rvalid / m1_rvalid  out  1  response valid.
- m0_rdata / m1_rdata  out  DATA_WIDTH  response data (slave_rdata broadcast; qualify with rvalid).
- s_req  out  1  request to slave.
- s_addr, s_we, s_be, s_wdata  out  as above  muxed payload of the selected master.
- s_gnt  in  1  slave accepts s_req.
- s_rvalid  in  1  slave response; at least 1 cycle after the matching gnt, in order.
- s_rdata  in  DATA_WIDTH  slave read data.
- outstanding_cnt  out  log2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- protocol_error  out  1  sticky: s_rvalid received with FIFO empty.

Behaviour:
- State: priority pointer prio (0 = m0 preferred), ID FIFO (1-bit master IDs, rd/wr pointers, count), protocol_error flag.
- Reset (async, reset_n low): prio=0, FIFO empty, count=0, protocol_error=0. While reset_n low, s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid are forced 0.
- Selection (combinational, each cycle):
  - only one req high: select that master;
  - both high: select the prio master.
  - s_addr/we/be/wdata follow the selected master; with no req they follow m0.
- s_req = (m0_req | m1_req) & !full. Full means count == MAX_OUTSTANDING.
- Grant: the selected master's gnt = s_req & s_gnt (zero latency). The other master's gnt = 0.
- On accept (s_req & s_gnt):
  - push the selected ID;
  - if both masters were requesting, prio toggles to the non-selected master;
  - single-requester accepts leave prio unchanged.
- Response: on s_rvalid with FIFO non-empty:
  - mX_rvalid = 1 for X = FIFO head, same cycle (combinational);
  - pop.
- s_rvalid with FIFO empty: no rvalid to either master, protocol_error set (sticky until reset).
- Simultaneous accept and s_rvalid: push and pop both happen, count unchanged.
- Full: s_req is 0 even if a pop occurs that cycle; there is no bypass. The grant can occur the next cycle at the earliest.
- Pointers wrap modulo MAX_OUTSTANDING. count saturates neither way, because the full/empty guards prevent overflow.
- Masters may drop req only after gnt. The arbiter does not check this.
- Reset mid-transaction: FIFO cleared. Responses arriving after reset release flag protocol_error.
- outstanding_cnt = count, registered.

Test Plan:
1. Reset then idle: reset_n low 10 cycles, s_gnt=1 -> all gnt/rvalid/s_req 0, outstanding_cnt=0, protocol_error=0.
2. Single master: m0 reads addr 0x1A10_0000, s_gnt=1, s_rvalid one cycle later with rdata 0x0000_0001 -> m0_gnt pulse on cycle 0, m0_rvalid with 0x1 on cycle 1, m1 signals 0.
3. Contention round-robin: both masters request continuously, s_gnt=1, slave responds 1 cycle later -> grants alternate m0, m1, m0, m1. Each rvalid is routed to the matching master in order.
4. Backpressure/full: s_gnt=1, s_rvalid held 0, m1 requesting -> exactly 4 grants, then s_req=0 and outstanding_cnt=4. Release one s_rvalid -> m1_rvalid, and the next grant occurs one cycle after the pop.
5. Simultaneous push/pop at count=2: accept and s_rvalid in the same cycle -> count stays 2, head ID delivered correctly.
6. Spurious response: s_rvalid=1 with FIFO empty -> no mX_rvalid, protocol_error=1 and held; cleared only by reset_n low.
